// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing one single-port synchronous VRAM between the CPU bus
// and the playfield / motion-object fetch pipeline, paced by the pixel strobe.
module vram_slot_arbiter #(
  parameter int         ADDR_W  = 15,
  parameter int         DATA_W  = 16,
  parameter logic [2:0] PF_SLOT = 3'd0,
  parameter logic [2:0] MO_SLOT = 3'd4
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [8:0]        hcount,
  input  logic              hblank_b,
  input  logic              vblank_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic [DATA_W-1:0] pf_data,
  output logic              pf_valid,
  input  logic [ADDR_W-1:0] mo_addr,
  output logic [DATA_W-1:0] mo_data,
  output logic              mo_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        fsm_state
);

  // Handshake: a slot is granted only on a pix_ce cycle while IDLE; the matching
  // strobe (pf_valid / mo_valid / cpu_ack) is a single cycle, three edges later.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PF   = 2'd1,
    GNT_MO   = 2'd2,
    GNT_CPU  = 2'd3
  } gnt_t;

  state_t state, state_nxt;
  gnt_t   gnt_sel, gnt_q;
  logic   active;
  logic   start;

  // Only the low three hcount bits select a slot; the upper bits are ignored.
  logic unused_hcount_hi;
  assign unused_hcount_hi = ^hcount[8:3];

  assign fsm_state = state;

  always_comb begin
    active  = hblank_b & vblank_b;
    gnt_sel = GNT_NONE;
    if (active && (hcount[2:0] == PF_SLOT)) begin
      gnt_sel = GNT_PF;
    end else if (active && (hcount[2:0] == MO_SLOT)) begin
      gnt_sel = GNT_MO;
    end else if (cpu_req) begin
      gnt_sel = GNT_CPU;
    end
  end

  // A pix_ce seen outside IDLE is dropped so the in-flight access completes.
  assign start = (state == IDLE) && pix_ce && (gnt_sel != GNT_NONE);

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      gnt_q     <= GNT_NONE;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      pf_valid  <= 1'b0;
      pf_data   <= '0;
      mo_valid  <= 1'b0;
      mo_data   <= '0;
    end else begin
      ram_we   <= 1'b0;
      cpu_ack  <= 1'b0;
      pf_valid <= 1'b0;
      mo_valid <= 1'b0;

      if (start) begin
        gnt_q <= gnt_sel;
        case (gnt_sel)
          GNT_PF:  ram_addr <= pf_addr;
          GNT_MO:  ram_addr <= mo_addr;
          default: ram_addr <= cpu_addr;
        endcase
        if (gnt_sel == GNT_CPU) begin
          ram_we    <= cpu_we;
          ram_wdata <= cpu_wdata;
        end
      end

      // RAM output is valid in WAIT; capture it and raise the strobe for CAPTURE.
      if (state == WAIT) begin
        case (gnt_q)
          GNT_PF: begin
            pf_data  <= ram_rdata;
            pf_valid <= 1'b1;
          end
          GNT_MO: begin
            mo_data  <= ram_rdata;
            mo_valid <= 1'b1;
          end
          GNT_CPU: begin
            cpu_rdata <= ram_rdata;
            cpu_ack   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: behavioural RAM, cycle-level reference model with an
// expected-access queue, directed slot scenarios and a randomized mixed run.
module tb_vram_slot_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam logic [2:0] PF_S = 3'd0;
  localparam logic [2:0] MO_S = 3'd4;

  logic          clk100 = 1'b0;
  logic          rst = 1'b1;
  logic          pix_ce = 1'b0;
  logic [8:0]    hcount = '0;
  logic          hblank_b = 1'b1;
  logic          vblank_b = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] pf_addr = '0;
  logic [DW-1:0] pf_data;
  logic          pf_valid;
  logic [AW-1:0] mo_addr = '0;
  logic [DW-1:0] mo_data;
  logic          mo_valid;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [1:0]    fsm_state;

  vram_slot_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PF_SLOT(PF_S), .MO_SLOT(MO_S)) dut (
    .clk100(clk100), .rst(rst), .pix_ce(pix_ce), .hcount(hcount),
    .hblank_b(hblank_b), .vblank_b(vblank_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .pf_addr(pf_addr), .pf_data(pf_data), .pf_valid(pf_valid),
    .mo_addr(mo_addr), .mo_data(mo_data), .mo_valid(mo_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk100 = ~clk100;
  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  // ---------------- behavioural RAM (registered read, old data on write) ----------------
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk100) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // kind: 1 = playfield, 2 = motion object, 3 = CPU; t = cycle of the granting pix_ce
  typedef struct packed {
    int            t;
    logic [1:0]    kind;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          h, nx;
  bit            have, strobe, act;
  int            last_start = -100;
  logic [AW-1:0] held_addr = '0;
  logic [DW-1:0] held_pf = '0, held_mo = '0, held_cpu = '0;
  bit            cpu_rd_known = 1'b1;
  int            ack_seen = 0, pf_seen = 0, mo_seen = 0, we_seen = 0;

  always @(negedge clk100) begin
    if (rst) begin
      exp_q.delete();
      last_start   = -100;
      held_addr    = '0;
      held_pf      = '0;
      held_mo      = '0;
      held_cpu     = '0;
      cpu_rd_known = 1'b1;
    end else begin
      have = (exp_q.size() > 0);
      if (have) h = exp_q[0];
      check_eq("ram_we", ram_we, have && h.wr && (cyc == h.t + 1));
      if (have && h.wr && (cyc == h.t + 1)) check_eq("ram_wdata", ram_wdata, h.wdata);
      check_eq("ram_addr", ram_addr, held_addr);
      strobe = have && (cyc == h.t + 3);
      check_eq("pf_valid", pf_valid, strobe && (h.kind == 2'd1));
      check_eq("mo_valid", mo_valid, strobe && (h.kind == 2'd2));
      check_eq("cpu_ack", cpu_ack, strobe && (h.kind == 2'd3));
      if (strobe) begin
        case (h.kind)
          2'd1: held_pf = h.rdata;
          2'd2: held_mo = h.rdata;
          default: begin
            if (h.wr) begin
              cpu_rd_known = 1'b0;
              ref_mem[h.addr] = h.wdata;
            end else begin
              cpu_rd_known = 1'b1;
              held_cpu = h.rdata;
            end
          end
        endcase
        void'(exp_q.pop_front());
      end
      check_eq("pf_data", pf_data, held_pf);
      check_eq("mo_data", mo_data, held_mo);
      if (cpu_rd_known) check_eq("cpu_rdata", cpu_rdata, held_cpu);
      if (cpu_ack) ack_seen++;
      if (pf_valid) pf_seen++;
      if (mo_valid) mo_seen++;
      if (ram_we) we_seen++;

      // slot schedule: an access occupies its pix_ce cycle and the three after it
      if (pix_ce && (cyc > last_start + 3)) begin
        act = hblank_b && vblank_b;
        nx = '0;
        nx.t = cyc;
        if (act && (hcount[2:0] == PF_S)) begin
          nx.kind = 2'd1; nx.addr = pf_addr;
        end else if (act && (hcount[2:0] == MO_S)) begin
          nx.kind = 2'd2; nx.addr = mo_addr;
        end else if (cpu_req) begin
          nx.kind = 2'd3; nx.addr = cpu_addr; nx.wr = cpu_we; nx.wdata = cpu_wdata;
        end
        if (nx.kind != 2'd0) begin
          nx.rdata = ref_mem[nx.addr];
          exp_q.push_back(nx);
          last_start = cyc;
          held_addr = nx.addr;
        end
      end
    end
  end

  // ---------------- driver tasks (all drives at posedge + 1) ----------------
  bit         pix_done = 1'b1;
  logic [8:0] h_next = '0;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk100); #1;
    end
  endtask

  task automatic pix_pulse(input logic [8:0] hc, input int gap);
    hcount = hc;
    pix_ce = 1'b1;
    @(posedge clk100); #1;
    pix_ce = 1'b0;
    idle(gap - 1);
  endtask

  task automatic pix_run(input int n, input bit rnd_blank, input int gap_min);
    int gap;
    for (int i = 0; i < n; i++) begin
      if (rnd_blank) begin
        hblank_b = (h_next < 9'd400);
        if (i % 64 == 0) vblank_b = ($urandom_range(0, 3) != 0);
        pf_addr = AW'($urandom_range(0, 127));
        mo_addr = AW'($urandom_range(0, 127));
        gap = ($urandom_range(0, 15) == 0) ? 2 : int'($urandom_range(4, 7));
      end else begin
        gap = gap_min;
      end
      pix_pulse(h_next, gap);
      h_next = h_next + 9'd1;
    end
    pix_done = 1'b1;
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit keep);
    int k;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    k = 0;
    while (k < 400) begin
      @(negedge clk100);
      if (cpu_ack) break;
      if (pix_done && exp_q.size() == 0) break;
      k++;
    end
    if (k == 400) check_eq("cpu_ack_timeout", cpu_ack, 1'b1);
    @(posedge clk100); #1;
    if (!keep) cpu_req = 1'b0;
  endtask

  task automatic cpu_run();
    while (!pix_done) begin
      idle($urandom_range(0, 6));
      if (pix_done) break;
      if ($urandom_range(0, 5) == 0) begin
        cpu_we = $urandom_range(0, 1); cpu_addr = AW'($urandom_range(0, 63));
        cpu_wdata = DW'($urandom);
        cpu_req = 1'b1;
        idle(1);
        cpu_req = 1'b0;
      end else begin
        cpu_access($urandom_range(0, 1), AW'($urandom_range(0, 63)), DW'($urandom),
                   $urandom_range(0, 1));
      end
    end
    cpu_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int            a0, p0, m0, w0, diffs;
  logic [DW-1:0] saved;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = DW'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    rst = 1'b1;
    repeat (3) @(posedge clk100);
    #1;
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_fsm_state", fsm_state, 0);
    check_eq("rst_outputs", {cpu_ack, pf_valid, mo_valid, cpu_rdata, pf_data, mo_data}, 0);
    rst = 1'b0;
    idle(2);

    // reset in the middle of a CPU write
    saved = ram_mem[15'h0055];
    a0 = ack_seen;
    vblank_b = 1'b0; hcount = 9'd1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0055; cpu_wdata = 16'hA5A5;
    pix_ce = 1'b1;
    @(posedge clk100); #1;
    pix_ce = 1'b0; cpu_req = 1'b0;
    #2;
    check_eq("t1_we_issued", ram_we, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t1_we_dropped", ram_we, 1'b0);
    check_eq("t1_addr_cleared", {ram_addr, ram_wdata}, 0);
    check_eq("t1_strobes_clear", {cpu_ack, pf_valid, mo_valid}, 0);
    idle(3);
    rst = 1'b0;
    idle(8);
    check_eq("t1_no_ack", ack_seen, a0);
    check_eq("t1_mem_untouched", ram_mem[15'h0055], saved);

    // active display: PF slot at 0x040 preempts the CPU, CPU read granted at 0x041
    vblank_b = 1'b1; hblank_b = 1'b1;
    a0 = ack_seen; p0 = pf_seen;
    pf_addr = 15'h0300;
    pix_done = 1'b0;
    h_next = 9'h040;
    fork
      pix_run(3, 1'b0, 4);
      cpu_access(1'b0, 15'h1234, 16'h0000, 1'b0);
    join
    idle(4);
    check_eq("t2_ack_count", ack_seen - a0, 1);
    check_eq("t2_pf_count", pf_seen - p0, 1);
    check_eq("t2_rdata", cpu_rdata, ref_mem[15'h1234]);

    // active display: playfield and motion-object fetches only
    p0 = pf_seen; m0 = mo_seen; w0 = we_seen;
    pf_addr = 15'h0100; pix_pulse(9'h048, 4);
    mo_addr = 15'h2000; pix_pulse(9'h04C, 4);
    idle(4);
    check_eq("t3_pf_count", pf_seen - p0, 1);
    check_eq("t3_mo_count", mo_seen - m0, 1);
    check_eq("t3_no_write", we_seen - w0, 0);
    check_eq("t3_pf_data", pf_data, ref_mem[15'h0100]);
    check_eq("t3_mo_data", mo_data, ref_mem[15'h2000]);

    // horizontal blank: the PF slot becomes a CPU write slot
    hblank_b = 1'b0;
    p0 = pf_seen; w0 = we_seen;
    pix_done = 1'b0;
    h_next = 9'h050;
    fork
      pix_run(2, 1'b0, 4);
      cpu_access(1'b1, 15'h0007, 16'hBEEF, 1'b0);
    join
    idle(4);
    check_eq("t4_we_cycles", we_seen - w0, 1);
    check_eq("t4_no_pf", pf_seen - p0, 0);
    check_eq("t4_mem", ram_mem[15'h0007], 16'hBEEF);

    // vertical blank: eight back-to-back writes with cpu_req held
    hblank_b = 1'b1; vblank_b = 1'b0;
    a0 = ack_seen;
    pix_done = 1'b0;
    h_next = 9'h100;
    fork
      pix_run(8, 1'b0, 4);
      for (int i = 0; i < 8; i++) cpu_access(1'b1, AW'(16'h0200 + i), DW'(16'hC000 + i), i != 7);
    join
    idle(4);
    check_eq("t5_ack_count", ack_seen - a0, 8);
    for (int i = 0; i < 8; i++) check_eq("t5_mem", ram_mem[16'h0200 + i], 16'hC000 + i);

    // request withdrawn before any eligible slot
    a0 = ack_seen; w0 = we_seen;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0300; cpu_wdata = 16'h1111;
    idle(2);
    cpu_req = 1'b0;
    idle(1);
    h_next = 9'h110;
    pix_run(4, 1'b0, 5);
    idle(4);
    check_eq("t6_no_ack", ack_seen - a0, 0);
    check_eq("t6_no_write", we_seen - w0, 0);

    // randomized mixed traffic with blanking, hcount wrap and stray pix_ce
    vblank_b = 1'b1;
    h_next = 9'd480;
    pix_done = 1'b0;
    fork
      pix_run(400, 1'b1, 4);
      cpu_run();
    join
    cpu_req = 1'b0;
    idle(10);

    diffs = 0;
    for (int i = 0; i < (1 << AW); i++) if (ram_mem[i] !== ref_mem[i]) diffs++;
    check_eq("mem_contents", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
